// File: rtl/oc4_vc3_pkg.sv
// Shared types and constants for the OC4 VC3/DCP3 command credit gate.
package oc4_vc3_pkg;

    localparam int CMD_W      = 223;
    localparam int FLIT_W     = 512;
    localparam int DFLITS_W   = 3;
    localparam int VC3_CNT_W  = 5;
    localparam int DCP3_CNT_W = 7;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [3:0]  stream_id;
        logic [15:0] afutag;
        logic [11:0] actag;
        logic [67:0] ea_or_obj;
        logic [2:0]  pl;
        logic        os;
        logic [63:0] be;
        logic [3:0]  flag;
        logic        endian;
        logic [15:0] bdf;
        logic [19:0] pasid;
        logic [5:0]  pg_size;
    } cmd_t;

endpackage

// File: rtl/oc4_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count and overflow strobe.
module oc4_sync_fifo
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic [CNT_W-1:0] o_count,
    output logic             o_overflow
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_full;
    logic             w_wr;
    logic             w_rd;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        ptr_inc = (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A push into a full FIFO is still accepted when a pop frees a slot in the same cycle.
    assign w_full     = (r_count == CNT_W'(DEPTH));
    assign w_rd       = i_pop && (r_count != '0);
    assign w_wr       = i_push && (!w_full || w_rd);
    assign o_overflow = i_push && w_full && !w_rd;
    assign o_data     = r_mem[r_rd_ptr];
    assign o_count    = r_count;

    always_ff @(posedge clock) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_rd) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/oc4_vc3_cmd_credit_gate.sv
// Buffers AFU commands and data flits and releases each command to VC3/DCP3
// once host credits and all of its data flits are available.
module oc4_vc3_cmd_credit_gate
    import oc4_vc3_pkg::*;
#(
    parameter int CMD_DEPTH  = 8,
    parameter int DATA_DEPTH = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              afu_tlx_cmd_valid,
    input  logic [CMD_W-1:0]  afu_tlx_cmd_payload,
    input  logic [1:0]        afu_tlx_cmd_dl,
    input  logic [2:0]        afu_tlx_cmd_dflits,
    input  logic              afu_tlx_cdata_valid,
    input  logic [511:0]      afu_tlx_cdata_bus,
    input  logic              afu_tlx_cdata_bdi,
    output logic [3:0]        tlx_afu_cmd_resp_initial_credit,
    output logic [5:0]        tlx_afu_cmd_data_initial_credit,
    output logic              tlx_afu_cmd_credit,
    output logic              tlx_afu_cmd_data_credit,
    input  logic [3:0]        tlx_afu_vc3_initial_credit,
    input  logic [5:0]        tlx_afu_dcp3_initial_credit,
    input  logic              tlx_afu_vc3_credit,
    input  logic              tlx_afu_dcp3_credit,
    output logic              afu_tlx_vc3_valid,
    output logic [CMD_W-1:0]  afu_tlx_vc3_payload,
    output logic [1:0]        afu_tlx_vc3_dl,
    output logic              afu_tlx_dcp3_data_valid,
    output logic [511:0]      afu_tlx_dcp3_data_bus,
    output logic              afu_tlx_dcp3_data_bdi,
    output logic [1:0]        err_status
);

    localparam int CCNT_W = $clog2(CMD_DEPTH + 1);
    localparam int DCNT_W = $clog2(DATA_DEPTH + 1);
    localparam int CENT_W = CMD_W + 2 + DFLITS_W;
    localparam int DENT_W = FLIT_W + 1;

    logic [CENT_W-1:0]       w_cmd_head;
    logic [CCNT_W-1:0]       w_cmd_count;
    logic                    w_cmd_ovf;
    logic [DENT_W-1:0]       w_data_head;
    logic [DCNT_W-1:0]       w_data_count;
    logic                    w_data_ovf;
    logic [DFLITS_W-1:0]     w_head_n;
    logic                    w_issue;
    logic                    w_data_pop;
    logic [VC3_CNT_W:0]      w_vc3_sum;
    logic [DCP3_CNT_W:0]     w_dcp3_sum;

    logic [0:0]              r_state;
    logic [DFLITS_W-1:0]     r_rem;
    logic                    r_init_done;
    logic [VC3_CNT_W-1:0]    r_vc3_cnt;
    logic [DCP3_CNT_W-1:0]   r_dcp3_cnt;
    logic                    r_s1_cmd_vld;
    logic [CMD_W+1:0]        r_s1_cmd;
    logic                    r_s1_dat_vld;
    logic [DENT_W-1:0]       r_s1_dat;

    assign tlx_afu_cmd_resp_initial_credit = 4'(CMD_DEPTH);
    assign tlx_afu_cmd_data_initial_credit = 6'(DATA_DEPTH);

    oc4_sync_fifo #(.WIDTH(CENT_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .i_push     (afu_tlx_cmd_valid),
        .i_data     ({afu_tlx_cmd_payload, afu_tlx_cmd_dl, afu_tlx_cmd_dflits}),
        .i_pop      (w_issue),
        .o_data     (w_cmd_head),
        .o_count    (w_cmd_count),
        .o_overflow (w_cmd_ovf)
    );

    oc4_sync_fifo #(.WIDTH(DENT_W), .DEPTH(DATA_DEPTH)) u_data_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .i_push     (afu_tlx_cdata_valid),
        .i_data     ({afu_tlx_cdata_bdi, afu_tlx_cdata_bus}),
        .i_pop      (w_data_pop),
        .o_data     (w_data_head),
        .o_count    (w_data_count),
        .o_overflow (w_data_ovf)
    );

    assign w_head_n = w_cmd_head[DFLITS_W-1:0];

    // Issue only when every flit of the head command is already buffered.
    always_comb begin
        w_issue = 1'b0;
        if ((r_state == IDLE) && (w_cmd_count != '0) && r_init_done &&
            (r_vc3_cnt != '0) && (r_dcp3_cnt >= DCP3_CNT_W'(w_head_n)) &&
            (w_data_count >= DCNT_W'(w_head_n))) begin
            w_issue = 1'b1;
        end else begin
            w_issue = 1'b0;
        end
    end

    assign w_data_pop = (w_issue && (w_head_n != 3'd0)) || (r_state == STREAM);
    assign w_vc3_sum  = {1'b0, r_vc3_cnt} + (VC3_CNT_W+1)'(tlx_afu_vc3_credit)
                      - (VC3_CNT_W+1)'(w_issue);
    assign w_dcp3_sum = {1'b0, r_dcp3_cnt} + (DCP3_CNT_W+1)'(tlx_afu_dcp3_credit)
                      - (w_issue ? (DCP3_CNT_W+1)'(w_head_n) : (DCP3_CNT_W+1)'(0));

    // Host credit counters: one-shot load after reset, then saturating net update.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_init_done <= 1'b0;
            r_vc3_cnt   <= '0;
            r_dcp3_cnt  <= '0;
            err_status  <= 2'b00;
        end else begin
            if (!r_init_done) begin
                r_init_done <= 1'b1;
                r_vc3_cnt   <= VC3_CNT_W'(tlx_afu_vc3_initial_credit) + VC3_CNT_W'(tlx_afu_vc3_credit);
                r_dcp3_cnt  <= DCP3_CNT_W'(tlx_afu_dcp3_initial_credit) + DCP3_CNT_W'(tlx_afu_dcp3_credit);
            end else begin
                r_vc3_cnt  <= w_vc3_sum[VC3_CNT_W] ? '1 : w_vc3_sum[VC3_CNT_W-1:0];
                r_dcp3_cnt <= w_dcp3_sum[DCP3_CNT_W] ? '1 : w_dcp3_sum[DCP3_CNT_W-1:0];
            end
            err_status[0] <= err_status[0] | w_cmd_ovf | w_data_ovf;
            err_status[1] <= err_status[1] |
                             (r_init_done & (w_vc3_sum[VC3_CNT_W] | w_dcp3_sum[DCP3_CNT_W]));
        end
    end

    // Issue/stream FSM; r_rem counts flits still owed after the issue cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_rem   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_issue && (w_head_n > 3'd1)) begin
                        r_state <= STREAM;
                        r_rem   <= w_head_n - 3'd1;
                    end
                end
                STREAM: begin
                    r_rem <= r_rem - 3'd1;
                    if (r_rem == 3'd1) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_rem   <= '0;
                end
            endcase
        end
    end

    // Popped entries are staged one cycle, then driven out; AFU credits pulse at the pop edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_cmd_vld            <= 1'b0;
            r_s1_cmd                <= '0;
            r_s1_dat_vld            <= 1'b0;
            r_s1_dat                <= '0;
            tlx_afu_cmd_credit      <= 1'b0;
            tlx_afu_cmd_data_credit <= 1'b0;
            afu_tlx_vc3_valid       <= 1'b0;
            afu_tlx_vc3_payload     <= '0;
            afu_tlx_vc3_dl          <= 2'b00;
            afu_tlx_dcp3_data_valid <= 1'b0;
            afu_tlx_dcp3_data_bus   <= '0;
            afu_tlx_dcp3_data_bdi   <= 1'b0;
        end else begin
            r_s1_cmd_vld            <= w_issue;
            r_s1_cmd                <= w_cmd_head[CENT_W-1:DFLITS_W];
            r_s1_dat_vld            <= w_data_pop;
            r_s1_dat                <= w_data_head;
            tlx_afu_cmd_credit      <= w_issue;
            tlx_afu_cmd_data_credit <= w_data_pop;
            afu_tlx_vc3_valid       <= r_s1_cmd_vld;
            afu_tlx_vc3_payload     <= r_s1_cmd_vld ? r_s1_cmd[CMD_W+1:2] : '0;
            afu_tlx_vc3_dl          <= r_s1_cmd_vld ? r_s1_cmd[1:0] : 2'b00;
            afu_tlx_dcp3_data_valid <= r_s1_dat_vld;
            afu_tlx_dcp3_data_bus   <= r_s1_dat_vld ? r_s1_dat[FLIT_W-1:0] : '0;
            afu_tlx_dcp3_data_bdi   <= r_s1_dat_vld ? r_s1_dat[FLIT_W] : 1'b0;
        end
    end

endmodule
